// File: rtl/hashmap_upsert_if.sv
// hashmap_upsert_if: request/response and hashmap-side signal bundle for hashmap_upsert.
// The slave modport is the upsert engine's view; master is the view of whatever
// drives requests and emulates the hashmap.
interface hashmap_upsert_if #(
  parameter int NUM_KEY_BITS = 32,
  parameter int NUM_VAL_BITS = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic [NUM_KEY_BITS-1:0] req_key;
  logic [NUM_VAL_BITS-1:0] req_delta;
  logic                    req_del;

  logic                    resp_valid;
  logic                    resp_hit;
  logic [NUM_KEY_BITS-1:0] resp_key;
  logic [NUM_VAL_BITS-1:0] resp_old;
  logic [NUM_VAL_BITS-1:0] resp_new;

  logic                    hm_lookup;
  logic [NUM_KEY_BITS-1:0] hm_key;
  logic                    hm_valid;
  logic [NUM_VAL_BITS-1:0] hm_value;
  logic                    hm_modify;
  logic                    hm_del;
  logic [NUM_VAL_BITS-1:0] hm_mod_value;
  logic                    hm_insert;
  logic [NUM_KEY_BITS-1:0] hm_ins_key;
  logic [NUM_VAL_BITS-1:0] hm_ins_value;
  logic                    hm_busy;

  modport slave (
    input  req_valid, req_key, req_delta, req_del, hm_valid, hm_value, hm_busy,
    output req_ready, resp_valid, resp_hit, resp_key, resp_old, resp_new,
           hm_lookup, hm_key, hm_modify, hm_del, hm_mod_value,
           hm_insert, hm_ins_key, hm_ins_value
  );

  modport master (
    output req_valid, req_key, req_delta, req_del, hm_valid, hm_value, hm_busy,
    input  req_ready, resp_valid, resp_hit, resp_key, resp_old, resp_new,
           hm_lookup, hm_key, hm_modify, hm_del, hm_mod_value,
           hm_insert, hm_ins_key, hm_ins_value
  );
endinterface

// File: rtl/hashmap_upsert.sv
// hashmap_upsert: read-modify-write (upsert/delete) front end for an external
// hashmap with a fixed lookup latency. Hits become modify/delete operations,
// misses are queued in a small pending-insert FIFO that drains whenever the
// hashmap is not busy. Requests touching a key that is still in flight or
// pending are held off so every key sees its operations strictly in order.
// Defining HASHMAP_UPSERT_STATS_EN adds saturating hit/miss/stall counters.
module hashmap_upsert #(
  parameter int NUM_KEY_BITS = 32,
  parameter int NUM_VAL_BITS = 32,
  parameter int NUM_PIPES    = 2,
  parameter int PEND_DEPTH   = 4
) (
  input  logic clk,
  input  logic rst_n,
`ifdef HASHMAP_UPSERT_STATS_EN
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses,
  output logic [31:0] stat_stalls,
`endif
  hashmap_upsert_if.slave bus
);

  localparam int PW   = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;
  localparam int CW   = $clog2(PEND_DEPTH + 1);
  localparam int LAST = NUM_PIPES - 1;

  logic                    pipe_valid [NUM_PIPES];
  logic [NUM_KEY_BITS-1:0] pipe_key   [NUM_PIPES];
  logic [NUM_VAL_BITS-1:0] pipe_delta [NUM_PIPES];
  logic                    pipe_del   [NUM_PIPES];

  logic                    pend_vld   [PEND_DEPTH];
  logic [NUM_KEY_BITS-1:0] pend_key   [PEND_DEPTH];
  logic [NUM_VAL_BITS-1:0] pend_delta [PEND_DEPTH];
  logic [PW-1:0]           head;
  logic [PW-1:0]           tail;
  logic [CW-1:0]           pend_count;

  logic                    ready;
  logic                    accept;
  logic                    conflict;
  int                      occ;
  logic                    res_valid;
  logic                    res_hit;
  logic                    res_ins;
  logic                    bypass;
  logic                    push;
  logic                    pop;
  logic [NUM_VAL_BITS-1:0] sum_value;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(PEND_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Admission: same-key serialisation, occupancy limit, lookup launch, and miss/insert routing.
  always_comb begin
    conflict = 1'b0;
    occ      = int'(pend_count);
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (pipe_valid[i]) begin
        occ = occ + 1;
        if (pipe_key[i] == bus.req_key) conflict = 1'b1;
      end
    end
    for (int i = 0; i < PEND_DEPTH; i++) begin
      if (pend_vld[i] && pend_key[i] == bus.req_key) conflict = 1'b1;
    end
    ready         = rst_n && !conflict && (occ < PEND_DEPTH);
    accept        = bus.req_valid && ready;
    bus.req_ready = ready;
    bus.hm_lookup = accept;
    bus.hm_key    = accept ? bus.req_key : '0;

    res_valid = pipe_valid[LAST];
    res_hit   = res_valid && bus.hm_valid;
    res_ins   = res_valid && !bus.hm_valid && !pipe_del[LAST];
    pop       = (pend_count != '0) && !bus.hm_busy;
    bypass    = res_ins && (pend_count == '0) && !bus.hm_busy;
    push      = res_ins && !bypass;
    sum_value = bus.hm_value + pipe_delta[LAST];
  end

  // Response strobe and modify/delete port for the request resolving this cycle.
  always_comb begin
    bus.resp_valid   = res_valid;
    bus.resp_hit     = res_hit;
    bus.resp_key     = '0;
    bus.resp_old     = '0;
    bus.resp_new     = '0;
    bus.hm_modify    = 1'b0;
    bus.hm_del       = 1'b0;
    bus.hm_mod_value = '0;
    if (res_valid) begin
      bus.resp_key = pipe_key[LAST];
      if (res_hit) begin
        bus.resp_old  = bus.hm_value;
        bus.hm_modify = 1'b1;
        bus.hm_del    = pipe_del[LAST];
        if (!pipe_del[LAST]) begin
          bus.resp_new     = sum_value;
          bus.hm_mod_value = sum_value;
        end
      end else if (!pipe_del[LAST]) begin
        bus.resp_new = pipe_delta[LAST];
      end
    end
  end

  // Insert port: FIFO head has priority; a miss bypasses only when the FIFO is empty.
  always_comb begin
    bus.hm_insert    = pop || bypass;
    bus.hm_ins_key   = '0;
    bus.hm_ins_value = '0;
    if (pop) begin
      bus.hm_ins_key   = pend_key[head];
      bus.hm_ins_value = pend_delta[head];
    end else if (bypass) begin
      bus.hm_ins_key   = pipe_key[LAST];
      bus.hm_ins_value = pipe_delta[LAST];
    end
  end

  // Lookup-latency pipeline carrying each accepted request to its resolve cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_key[i]   <= '0;
        pipe_delta[i] <= '0;
        pipe_del[i]   <= 1'b0;
      end
    end else begin
      pipe_valid[0] <= accept;
      pipe_key[0]   <= bus.req_key;
      pipe_delta[0] <= bus.req_delta;
      pipe_del[0]   <= bus.req_del;
      for (int i = 1; i < NUM_PIPES; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_key[i]   <= pipe_key[i-1];
        pipe_delta[i] <= pipe_delta[i-1];
        pipe_del[i]   <= pipe_del[i-1];
      end
    end
  end

  // Pending-insert FIFO; admission control guarantees a push never lands on a full FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PEND_DEPTH; i++) begin
        pend_vld[i]   <= 1'b0;
        pend_key[i]   <= '0;
        pend_delta[i] <= '0;
      end
      head       <= '0;
      tail       <= '0;
      pend_count <= '0;
    end else begin
      if (pop) begin
        pend_vld[head] <= 1'b0;
        head           <= next_ptr(head);
      end
      if (push) begin
        pend_vld[tail]   <= 1'b1;
        pend_key[tail]   <= pipe_key[LAST];
        pend_delta[tail] <= pipe_delta[LAST];
        tail             <= next_ptr(tail);
      end
      if (push && !pop)      pend_count <= pend_count + CW'(1);
      else if (pop && !push) pend_count <= pend_count - CW'(1);
    end
  end

`ifdef HASHMAP_UPSERT_STATS_EN
  // Saturating counters of hit resolves, miss resolves and stalled request cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_stalls <= '0;
    end else begin
      if (res_hit && stat_hits != '1)                 stat_hits   <= stat_hits + 32'd1;
      if (res_valid && !res_hit && stat_misses != '1) stat_misses <= stat_misses + 32'd1;
      if (bus.req_valid && !ready && stat_stalls != '1) stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hashmap_upsert.sv
// tb_hashmap_upsert: directed plus randomized bench for hashmap_upsert.
// The bench emulates the external hashmap (fixed lookup latency, modify/insert
// applied from the DUT's ports) and keeps a separate logical key/value store
// updated at request acceptance, from which every response, modify, insert and
// the ready decision are predicted.
module tb_hashmap_upsert;
  localparam int KB = 32;
  localparam int VB = 32;
  localparam int NP = 2;
  localparam int PD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hashmap_upsert_if #(.NUM_KEY_BITS(KB), .NUM_VAL_BITS(VB)) bus ();

`ifdef HASHMAP_UPSERT_STATS_EN
  logic [31:0] stat_hits, stat_misses, stat_stalls;
`endif

  hashmap_upsert #(
    .NUM_KEY_BITS(KB), .NUM_VAL_BITS(VB), .NUM_PIPES(NP), .PEND_DEPTH(PD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef HASHMAP_UPSERT_STATS_EN
    .stat_hits(stat_hits),
    .stat_misses(stat_misses),
    .stat_stalls(stat_stalls),
`endif
    .bus(bus)
  );

  typedef struct {
    int         due;
    logic [31:0] key;
    bit         del;
    bit         hit;
    logic [31:0] old_v;
    logic [31:0] new_v;
  } resp_t;

  typedef struct {
    logic [31:0] key;
    logic [31:0] val;
  } ins_t;

  resp_t       rq[$];
  ins_t        pq[$];
  bit          lat_v[$];
  logic [31:0] lat_d[$];
  logic [31:0] lat_k[$];
  logic [31:0] hm_map[logic [31:0]];
  logic [31:0] ref_map[logic [31:0]];
  logic [31:0] cur_lk_key;
  int          now = 0;
  int          checks = 0;
  int          errors = 0;
  bit          accepted;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mapv(input logic [31:0] k);
    return hm_map.exists(k) ? hm_map[k] : 32'hDEAD_BEEF;
  endfunction

  task automatic clear_lat();
    lat_v.delete(); lat_d.delete(); lat_k.delete();
    for (int i = 0; i < NP; i++) begin
      lat_v.push_back(1'b0); lat_d.push_back('0); lat_k.push_back('0);
    end
  endtask

  // One clock cycle: drive hashmap result, predict and compare, update models.
  task automatic cycle();
    bit    rdy_exp, conflict, res_now, hit;
    int    occ;
    resp_t r;
    logic [31:0] old_v, new_v;
    bus.hm_valid = lat_v.pop_front();
    bus.hm_value = lat_d.pop_front();
    cur_lk_key   = lat_k.pop_front();
    #4;
    conflict = 1'b0;
    occ = rq.size() + pq.size();
    foreach (rq[i]) if (rq[i].key == bus.req_key) conflict = 1'b1;
    foreach (pq[i]) if (pq[i].key == bus.req_key) conflict = 1'b1;
    rdy_exp = !conflict && (occ < PD);
    check("req_ready", bus.req_ready, rdy_exp);
    accepted = bus.req_valid && rdy_exp;
    check("hm_lookup", bus.hm_lookup, accepted);
    if (accepted) check("hm_key", bus.hm_key, bus.req_key);

    res_now = (rq.size() > 0) && (rq[0].due == now);
    check("resp_valid", bus.resp_valid, res_now);
    check("hm_modify", bus.hm_modify, res_now && rq[0].hit);
    if (res_now) begin
      r = rq.pop_front();
      check("resp_key", bus.resp_key, r.key);
      check("resp_hit", bus.resp_hit, r.hit);
      check("resp_old", bus.resp_old, r.old_v);
      check("resp_new", bus.resp_new, r.new_v);
      if (r.hit) begin
        check("hm_del", bus.hm_del, r.del);
        if (!r.del) check("hm_mod_value", bus.hm_mod_value, r.new_v);
      end else if (!r.del) begin
        pq.push_back('{key: r.key, val: r.new_v});
      end
    end
    if (bus.hm_modify) begin
      if (bus.hm_del) hm_map.delete(cur_lk_key);
      else hm_map[cur_lk_key] = bus.hm_mod_value;
    end

    check("hm_insert", bus.hm_insert, !bus.hm_busy && (pq.size() > 0));
    if (bus.hm_insert) begin
      if (pq.size() > 0) begin
        check("hm_ins_key", bus.hm_ins_key, pq[0].key);
        check("hm_ins_value", bus.hm_ins_value, pq[0].val);
        void'(pq.pop_front());
      end
      hm_map[bus.hm_ins_key] = bus.hm_ins_value;
    end

    lat_v.push_back(bus.hm_lookup && hm_map.exists(bus.hm_key));
    lat_d.push_back((bus.hm_lookup && hm_map.exists(bus.hm_key)) ? hm_map[bus.hm_key] : '0);
    lat_k.push_back(bus.hm_key);

    if (accepted) begin
      hit   = ref_map.exists(bus.req_key);
      old_v = hit ? ref_map[bus.req_key] : 32'd0;
      new_v = bus.req_del ? 32'd0 : old_v + bus.req_delta;
      if (bus.req_del) ref_map.delete(bus.req_key);
      else ref_map[bus.req_key] = new_v;
      rq.push_back('{due: now + NP, key: bus.req_key, del: bus.req_del,
                     hit: hit, old_v: old_v, new_v: new_v});
    end
    @(posedge clk);
    #1;
    now++;
  endtask

  task automatic applyStimulus(input logic [31:0] k, input logic [31:0] d, input bit del, input int limit);
    bus.req_valid = 1'b1;
    bus.req_key   = k;
    bus.req_delta = d;
    bus.req_del   = del;
    accepted = 1'b0;
    for (int n = 0; n < limit && !accepted; n++) cycle();
    check("accept_in_time", accepted, 1'b1);
    bus.req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    repeat (n) cycle();
  endtask

  // Hold reset for n cycles checking quiescent outputs, then resynchronise models.
  task automatic doReset(input int n);
    rst_n = 1'b0;
    bus.hm_valid = 1'b0;
    bus.req_valid = 1'b1;
    repeat (n) begin
      #4;
      check("rst_req_ready", bus.req_ready, 1'b0);
      check("rst_resp_valid", bus.resp_valid, 1'b0);
      check("rst_hm_lookup", bus.hm_lookup, 1'b0);
      check("rst_hm_modify", bus.hm_modify, 1'b0);
      check("rst_hm_insert", bus.hm_insert, 1'b0);
      check("rst_resp_key", bus.resp_key, '0);
      check("rst_hm_ins_key", bus.hm_ins_key, '0);
      @(posedge clk);
      #1;
      now++;
    end
    rst_n = 1'b1;
    bus.req_valid = 1'b0;
    rq.delete(); pq.delete();
    hm_map.delete(); ref_map.delete();
    clear_lat();
  endtask

  task automatic checkOutput();
    check("drain_rq", rq.size(), 0);
    check("drain_pq", pq.size(), 0);
    check("map_size", hm_map.size(), ref_map.size());
    foreach (ref_map[k]) check("map_entry", mapv(k), ref_map[k]);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_key = '0; bus.req_delta = '0; bus.req_del = 1'b0;
    bus.hm_valid = 1'b0; bus.hm_value = '0; bus.hm_busy = 1'b0;
    clear_lat();
    #1;
    doReset(3);

    // Miss into an empty map: bypass insert of 0x10 -> 5.
    applyStimulus(32'h10, 32'd5, 1'b0, 4);
    idle(3);
    check("map_0x10_insert", mapv(32'h10), 32'd5);

    // Hit with wrap-around addend.
    applyStimulus(32'h10, 32'hFFFF_FFFF, 1'b0, 4);
    idle(3);
    check("map_0x10_wrap", mapv(32'h10), 32'd4);

    // Back-to-back same key: second is held until the first resolves.
    applyStimulus(32'h10, 32'd3, 1'b0, 4);
    applyStimulus(32'h10, 32'd7, 1'b0, 8);
    idle(3);
    check("map_0x10_serial", mapv(32'h10), 32'd14);

    // Busy hashmap: four misses fill the FIFO, a fifth stalls, then all drain in order.
    bus.hm_busy = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(32'h100 + i, 32'd10 + i, 1'b0, 4);
    bus.req_valid = 1'b1; bus.req_key = 32'h104; bus.req_delta = 32'd1; bus.req_del = 1'b0;
    repeat (4) begin
      cycle();
      check("full_stall", accepted, 1'b0);
    end
    bus.req_valid = 1'b0;
    bus.hm_busy = 1'b0;
    applyStimulus(32'h104, 32'd1, 1'b0, 8);
    idle(8);
    check("map_0x103", mapv(32'h103), 32'd13);

    // Delete of an absent key: no map activity.
    applyStimulus(32'h20, 32'd0, 1'b1, 4);
    idle(3);
    check("map_0x20_absent", hm_map.exists(32'h20), 1'b0);

    // Delete of a present key.
    applyStimulus(32'h10, 32'd0, 1'b1, 4);
    idle(3);
    check("map_0x10_deleted", hm_map.exists(32'h10), 1'b0);

    // Randomized traffic over a small key set with random backpressure.
    for (int n = 0; n < 400; n++) begin
      bus.req_valid = ($urandom % 2) == 0;
      bus.req_key   = 32'h40 + $urandom_range(0, 5);
      bus.req_delta = $urandom;
      bus.req_del   = ($urandom % 8) == 0;
      bus.hm_busy   = ($urandom % 4) == 0;
      cycle();
    end
    bus.req_valid = 1'b0;
    bus.hm_busy = 1'b0;
    idle(10);
    checkOutput();

    // Reset with two requests in flight and one pending insert.
    bus.hm_busy = 1'b1;
    applyStimulus(32'h200, 32'd1, 1'b0, 4);
    applyStimulus(32'h201, 32'd2, 1'b0, 4);
    applyStimulus(32'h202, 32'd3, 1'b0, 4);
    check("pending_before_reset", pq.size(), 1);
    doReset(2);
    bus.hm_busy = 1'b0;
    applyStimulus(32'h10, 32'd5, 1'b0, 4);
    idle(5);
    check("map_0x10_post_reset", mapv(32'h10), 32'd5);
    checkOutput();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
